// File: rtl/debounce_pkg.sv
// rtl/debounce_pkg.sv - shared types, defaults and counter-width helper for the debouncer
package debounce_pkg;

    typedef enum logic {IDLE, CHECK} db_state_t;

    localparam int DEFAULT_DEBOUNCE_CYCLES = 48000;

    // Smallest width w with 2**w >= cycles.
    function automatic int min_cnt_w(input int cycles);
        for (int w = 0; w < 31; w++) begin
            if ((64'd1 << w) >= 64'(cycles)) return w;
        end
        return 31;
    endfunction

endpackage

// File: rtl/debounce_channel.sv
// rtl/debounce_channel.sv - one debounce channel (FSM, counter, optional MULTI_DEBOUNCER_SYNC_EN synchroniser)
module debounce_channel
    import debounce_pkg::*;
#(
    parameter int   DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES,
    parameter int   CNT_W           = 22,
    parameter logic RESET_VAL       = 1'b1
) (
    input  logic clk,
    input  logic reset,
    input  logic raw_i,
    input  logic restart,
    output logic db_o,
    output logic rise_o,
    output logic fall_o,
    output logic busy_o
);

    localparam logic [CNT_W-1:0] TERM = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic s;

`ifdef MULTI_DEBOUNCER_SYNC_EN
    logic sync1_q, sync2_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync1_q <= RESET_VAL;
            sync2_q <= RESET_VAL;
        end else begin
            sync1_q <= raw_i;
            sync2_q <= sync1_q;
        end
    end

    assign s = sync2_q;
`else
    assign s = raw_i;
`endif

    db_state_t        state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             db_q, db_d, rise_q, rise_d, fall_q, fall_d;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        db_d    = db_q;
        rise_d  = 1'b0;
        fall_d  = 1'b0;
        // restart overrides a terminal count, so no level change can slip through
        if (restart) begin
            state_d = IDLE;
            cnt_d   = '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (s != db_q) begin
                        state_d = CHECK;
                        cnt_d   = CNT_W'(1);
                    end
                end
                CHECK: begin
                    if (s == db_q) begin
                        state_d = IDLE;
                        cnt_d   = '0;
                    end else if (cnt_q == TERM) begin
                        db_d    = s;
                        rise_d  = s;
                        fall_d  = ~s;
                        state_d = IDLE;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
                default: begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            db_q    <= RESET_VAL;
            rise_q  <= 1'b0;
            fall_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            db_q    <= db_d;
            rise_q  <= rise_d;
            fall_q  <= fall_d;
        end
    end

    assign db_o   = db_q;
    assign rise_o = rise_q;
    assign fall_o = fall_q;
    assign busy_o = (state_q == CHECK);

endmodule

// File: rtl/multi_debouncer.sv
// rtl/multi_debouncer.sv - N-channel debouncer top; MULTI_DEBOUNCER_SYNC_EN adds 2-flop input synchronisers
module multi_debouncer
    import debounce_pkg::*;
#(
    parameter int                NUM_CH          = 4,
    parameter int                DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES,
    parameter int                CNT_W           = 22,
    parameter logic [NUM_CH-1:0] RESET_VAL       = '1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [NUM_CH-1:0] raw_in,
    input  logic              restart,
    output logic [NUM_CH-1:0] db_out,
    output logic [NUM_CH-1:0] rise,
    output logic [NUM_CH-1:0] fall,
    output logic [NUM_CH-1:0] busy
);

    if (CNT_W < min_cnt_w(DEBOUNCE_CYCLES)) begin : g_cnt_w_check
        $error("CNT_W too small for DEBOUNCE_CYCLES");
    end

    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        debounce_channel #(
            .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
            .CNT_W           (CNT_W),
            .RESET_VAL       (RESET_VAL[i])
        ) u_ch (
            .clk     (clk),
            .reset   (reset),
            .raw_i   (raw_in[i]),
            .restart (restart),
            .db_o    (db_out[i]),
            .rise_o  (rise[i]),
            .fall_o  (fall[i]),
            .busy_o  (busy[i])
        );
    end

endmodule

// File: tb/tb_multi_debouncer.sv
// tb/tb_multi_debouncer.sv - directed vector bench for multi_debouncer (MULTI_DEBOUNCER_SYNC_EN aware)
module tb_multi_debouncer;

    logic       clk = 1'b0;
    logic       reset;
    logic [3:0] raw_in;
    logic       restart;
    logic [3:0] db_out, rise, fall, busy;

    int checks = 0;
    int errors = 0;

    multi_debouncer #(
        .NUM_CH          (4),
        .DEBOUNCE_CYCLES (4),
        .CNT_W           (3),
        .RESET_VAL       (4'b1111)
    ) dut (
        .clk     (clk),
        .reset   (reset),
        .raw_in  (raw_in),
        .restart (restart),
        .db_out  (db_out),
        .rise    (rise),
        .fall    (fall),
        .busy    (busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [3:0] raw;
        logic       rst_cnt;
        logic [3:0] db;
        logic [3:0] rise;
        logic [3:0] fall;
        logic [3:0] busy;
    } vec_t;

    vec_t tbl[$];

    task automatic add(input logic [3:0] r, input logic rc, input logic [3:0] d,
                       input logic [3:0] ri, input logic [3:0] fa, input logic [3:0] bu);
        vec_t v;
        v.raw = r; v.rst_cnt = rc; v.db = d; v.rise = ri; v.fall = fa; v.busy = bu;
        tbl.push_back(v);
    endtask

    task automatic check(input string name, input logic [3:0] act, input logic [3:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
        end
    endtask

    task automatic check_all(input string tag, input logic [3:0] d, input logic [3:0] ri,
                             input logic [3:0] fa, input logic [3:0] bu);
        check({tag, ".db_out"}, db_out, d);
        check({tag, ".rise"},   rise,   ri);
        check({tag, ".fall"},   fall,   fa);
        check({tag, ".busy"},   busy,   bu);
    endtask

    initial begin
        // ch0 falls and is accepted on the 4th edge
        add(4'b1110, 0, 4'b1111, 4'b0000, 4'b0000, 4'b0001);
        add(4'b1110, 0, 4'b1111, 4'b0000, 4'b0000, 4'b0001);
        add(4'b1110, 0, 4'b1111, 4'b0000, 4'b0000, 4'b0001);
        add(4'b1110, 0, 4'b1110, 4'b0000, 4'b0001, 4'b0000);
        add(4'b1110, 0, 4'b1110, 4'b0000, 4'b0000, 4'b0000);
        // ch1 two-cycle glitch is rejected
        add(4'b1100, 0, 4'b1110, 4'b0000, 4'b0000, 4'b0010);
        add(4'b1100, 0, 4'b1110, 4'b0000, 4'b0000, 4'b0010);
        add(4'b1110, 0, 4'b1110, 4'b0000, 4'b0000, 4'b0000);
        add(4'b1110, 0, 4'b1110, 4'b0000, 4'b0000, 4'b0000);
        // ch0 rises, restart on the terminal-count edge, then a full recount
        add(4'b1111, 0, 4'b1110, 4'b0000, 4'b0000, 4'b0001);
        add(4'b1111, 0, 4'b1110, 4'b0000, 4'b0000, 4'b0001);
        add(4'b1111, 0, 4'b1110, 4'b0000, 4'b0000, 4'b0001);
        add(4'b1111, 1, 4'b1110, 4'b0000, 4'b0000, 4'b0000);
        add(4'b1111, 0, 4'b1110, 4'b0000, 4'b0000, 4'b0001);
        add(4'b1111, 0, 4'b1110, 4'b0000, 4'b0000, 4'b0001);
        add(4'b1111, 0, 4'b1110, 4'b0000, 4'b0000, 4'b0001);
        add(4'b1111, 0, 4'b1111, 4'b0001, 4'b0000, 4'b0000);
        add(4'b1111, 0, 4'b1111, 4'b0000, 4'b0000, 4'b0000);
        // ch2 and ch3 fall together
        add(4'b0011, 0, 4'b1111, 4'b0000, 4'b0000, 4'b1100);
        add(4'b0011, 0, 4'b1111, 4'b0000, 4'b0000, 4'b1100);
        add(4'b0011, 0, 4'b1111, 4'b0000, 4'b0000, 4'b1100);
        add(4'b0011, 0, 4'b0011, 4'b0000, 4'b1100, 4'b0000);
        add(4'b0011, 0, 4'b0011, 4'b0000, 4'b0000, 4'b0000);
        // ch3 chatters (3 high, 1 low) and never reaches terminal count
        for (int k = 0; k < 2; k++) begin
            add(4'b1011, 0, 4'b0011, 4'b0000, 4'b0000, 4'b1000);
            add(4'b1011, 0, 4'b0011, 4'b0000, 4'b0000, 4'b1000);
            add(4'b1011, 0, 4'b0011, 4'b0000, 4'b0000, 4'b1000);
            add(4'b0011, 0, 4'b0011, 4'b0000, 4'b0000, 4'b0000);
        end

        reset   = 1'b1;
        raw_in  = 4'b1111;
        restart = 1'b0;
        repeat (3) @(posedge clk);
        #1 check_all("reset", 4'b1111, 4'b0000, 4'b0000, 4'b0000);
        @(negedge clk) reset = 1'b0;

`ifdef MULTI_DEBOUNCER_SYNC_EN
        @(negedge clk) raw_in = 4'b1110;
        for (int k = 1; k <= 6; k++) begin
            @(posedge clk);
            #1 check_all($sformatf("sync_e%0d", k),
                         (k < 6) ? 4'b1111 : 4'b1110,
                         4'b0000,
                         (k == 6) ? 4'b0001 : 4'b0000,
                         (k >= 3 && k < 6) ? 4'b0001 : 4'b0000);
        end
`else
        for (int k = 0; k < 20; k++) begin
            @(posedge clk);
            #1 check_all($sformatf("idle%0d", k), 4'b1111, 4'b0000, 4'b0000, 4'b0000);
        end
        foreach (tbl[i]) begin
            @(negedge clk);
            raw_in  = tbl[i].raw;
            restart = tbl[i].rst_cnt;
            @(posedge clk);
            #1 check_all($sformatf("vec%0d", i), tbl[i].db, tbl[i].rise, tbl[i].fall, tbl[i].busy);
        end
        @(negedge clk) restart = 1'b0;
`endif

        // Reset arrives asynchronously mid-count.
        @(negedge clk) raw_in = 4'b0000;
        repeat (3) @(posedge clk);
`ifdef MULTI_DEBOUNCER_SYNC_EN
        #1 check("midcount.busy", busy, 4'b1110);
`else
        #1 check("midcount.busy", busy, 4'b0011);
`endif
        @(negedge clk);
        #2 reset = 1'b1;
        #1 check_all("async_reset", 4'b1111, 4'b0000, 4'b0000, 4'b0000);
        @(negedge clk);
        raw_in = 4'b1111;
        reset  = 1'b0;
        repeat (4) @(posedge clk);
        #1 check_all("post_reset", 4'b1111, 4'b0000, 4'b0000, 4'b0000);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
